// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline constants for the decode-stage hazard controller.
package hazard_detection_unit_pkg;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic [4:0] X0      = 5'd0;

  // True when a producer register r feeds one of the ID operands; x0 never hazards.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic use_rs2);
    return (r != X0) && ((r == rs1) || (use_rs2 && (r == rs2)));
  endfunction

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating up-counter used for the stall and flush performance statistics.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Decode-stage hazard controller: load-use and ID-branch bubbles, cache freeze,
// taken-branch IF/ID flush, and stall/flush event counters.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             IF_ID_use_rs2,
  input  logic             ID_branch,
  input  logic             ID_jalr,
  input  logic             branch_taken,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_regwrite,
  input  logic             ID_EX_memread,
  input  logic [4:0]       EX_MEM_rd,
  input  logic             EX_MEM_memread,
  input  logic             ICACHE_stall,
  input  logic             DCACHE_stall,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             pipe_write,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic       w_use_rs2;
  logic       w_ctrl;
  logic       w_freeze;
  logic       w_load_use;
  logic       w_br_alu;
  logic       w_br_mem;

  // jalr reads only rs1, so rs2 comparisons are masked for it
  assign w_use_rs2  = IF_ID_use_rs2 && !ID_jalr;
  assign w_ctrl     = ID_branch || ID_jalr;
  assign w_freeze   = ICACHE_stall || DCACHE_stall;
  assign w_load_use = ID_EX_memread && reg_match(ID_EX_rd, IF_ID_rs1, IF_ID_rs2, w_use_rs2);
  assign w_br_alu   = w_ctrl && ID_EX_regwrite && reg_match(ID_EX_rd, IF_ID_rs1, IF_ID_rs2, w_use_rs2);
  assign w_br_mem   = w_ctrl && EX_MEM_memread && reg_match(EX_MEM_rd, IF_ID_rs1, IF_ID_rs2, w_use_rs2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Priority decode; reset forces the pass-through controls
  always_comb begin
    w_state_nxt  = r_state;
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    pipe_write   = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    if (rst) begin
      w_state_nxt = ST_RUN;
    end else if (w_freeze) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      pipe_write  = 1'b0;
    end else if (r_state == ST_WAIT) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
      w_state_nxt  = ST_RUN;
    end else if (w_load_use || w_br_alu || w_br_mem) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
      if (w_load_use && w_ctrl) begin
        w_state_nxt = ST_WAIT;
      end
    end else if (branch_taken) begin
      IF_ID_flush = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!PC_write),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (IF_ID_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit: directed vectors push expectations,
// a negedge monitor pops and compares.
module tb_hazard_detection_unit;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs2;
    logic       br;
    logic       jalr;
    logic       taken;
    logic [4:0] exrd;
    logic       exrw;
    logic       exmr;
    logic [4:0] memrd;
    logic       memmr;
    logic       ic;
    logic       dc;
  } vin_t;

  typedef struct packed {
    logic [4:0]  ctrl;   // {PC_write, IF_ID_write, pipe_write, ID_EX_bubble, IF_ID_flush}
    logic [31:0] stall;
    logic [31:0] flush;
    logic [3:0]  stall4;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd;
  logic IF_ID_use_rs2, ID_branch, ID_jalr, branch_taken;
  logic ID_EX_regwrite, ID_EX_memread, EX_MEM_memread, ICACHE_stall, DCACHE_stall;
  logic PC_write, IF_ID_write, pipe_write, ID_EX_bubble, IF_ID_flush;
  logic [31:0] stall_cycles, flush_count;
  logic PC_write4, IF_ID_write4, pipe_write4, ID_EX_bubble4, IF_ID_flush4;
  logic [3:0] stall_cycles4, flush_count4;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   m_stall = 0;
  int   m_flush = 0;

  always #5 clk = ~clk;

  hazard_detection_unit #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .IF_ID_use_rs2(IF_ID_use_rs2), .ID_branch(ID_branch), .ID_jalr(ID_jalr),
    .branch_taken(branch_taken), .ID_EX_rd(ID_EX_rd), .ID_EX_regwrite(ID_EX_regwrite),
    .ID_EX_memread(ID_EX_memread), .EX_MEM_rd(EX_MEM_rd), .EX_MEM_memread(EX_MEM_memread),
    .ICACHE_stall(ICACHE_stall), .DCACHE_stall(DCACHE_stall), .PC_write(PC_write),
    .IF_ID_write(IF_ID_write), .pipe_write(pipe_write), .ID_EX_bubble(ID_EX_bubble),
    .IF_ID_flush(IF_ID_flush), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_detection_unit #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .IF_ID_use_rs2(IF_ID_use_rs2), .ID_branch(ID_branch), .ID_jalr(ID_jalr),
    .branch_taken(branch_taken), .ID_EX_rd(ID_EX_rd), .ID_EX_regwrite(ID_EX_regwrite),
    .ID_EX_memread(ID_EX_memread), .EX_MEM_rd(EX_MEM_rd), .EX_MEM_memread(EX_MEM_memread),
    .ICACHE_stall(ICACHE_stall), .DCACHE_stall(DCACHE_stall), .PC_write(PC_write4),
    .IF_ID_write(IF_ID_write4), .pipe_write(pipe_write4), .ID_EX_bubble(ID_EX_bubble4),
    .IF_ID_flush(IF_ID_flush4), .stall_cycles(stall_cycles4), .flush_count(flush_count4)
  );

  task automatic drive(input vin_t v);
    rst = v.rst; IF_ID_rs1 = v.rs1; IF_ID_rs2 = v.rs2; IF_ID_use_rs2 = v.use_rs2;
    ID_branch = v.br; ID_jalr = v.jalr; branch_taken = v.taken;
    ID_EX_rd = v.exrd; ID_EX_regwrite = v.exrw; ID_EX_memread = v.exmr;
    EX_MEM_rd = v.memrd; EX_MEM_memread = v.memmr;
    ICACHE_stall = v.ic; DCACHE_stall = v.dc;
  endtask

  // One cycle of stimulus; counters expected are those accumulated before this cycle
  task automatic apply(input vin_t v, input logic [4:0] ctrl);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v);
    e.ctrl   = ctrl;
    e.stall  = 32'(m_stall);
    e.flush  = 32'(m_flush);
    e.stall4 = (m_stall > 15) ? 4'd15 : 4'(m_stall);
    sb_q.push_back(e);
    if (v.rst) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!ctrl[4]) m_stall++;
      if (ctrl[0])  m_flush++;
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [4:0] act;
      e = sb_q.pop_front();
      act = {PC_write, IF_ID_write, pipe_write, ID_EX_bubble, IF_ID_flush};
      total++;
      if (act !== e.ctrl) begin
        bad++;
        $display("FAIL ctrl t=%0t actual=%b required=%b", $time, act, e.ctrl);
      end
      total++;
      if (stall_cycles !== e.stall) begin
        bad++;
        $display("FAIL stall_cycles t=%0t actual=%0d required=%0d", $time, stall_cycles, e.stall);
      end
      total++;
      if (flush_count !== e.flush) begin
        bad++;
        $display("FAIL flush_count t=%0t actual=%0d required=%0d", $time, flush_count, e.flush);
      end
      total++;
      if (stall_cycles4 !== e.stall4) begin
        bad++;
        $display("FAIL stall_cycles4 t=%0t actual=%0d required=%0d", $time, stall_cycles4, e.stall4);
      end
    end
  end

  localparam logic [4:0] RUN_OK = 5'b11100;
  localparam logic [4:0] BUBBLE = 5'b00110;
  localparam logic [4:0] FREEZE = 5'b00000;
  localparam logic [4:0] FLUSH  = 5'b11101;

  initial begin
    vin_t v;
    v = '0;
    v.rst = 1'b1;
    drive(v);
    repeat (2) @(posedge clk);

    // reset overrides a live load-use hazard
    v = '0; v.rst = 1'b1; v.exmr = 1'b1; v.exrd = 5'd5; v.rs1 = 5'd5;
    apply(v, RUN_OK);
    v = '0; apply(v, RUN_OK);

    // load-use through rs2
    v = '0; v.exmr = 1'b1; v.exrd = 5'd5; v.rs2 = 5'd5; v.use_rs2 = 1'b1;
    apply(v, BUBBLE);
    v = '0; apply(v, RUN_OK);
    // rs2 not read: no hazard
    v = '0; v.exmr = 1'b1; v.exrd = 5'd5; v.rs2 = 5'd5;
    apply(v, RUN_OK);
    // x0 destination never stalls
    v = '0; v.exmr = 1'b1; v.exrd = 5'd0; v.rs1 = 5'd0;
    apply(v, RUN_OK);

    // load then beq on x7: bubble, WAIT bubble, then resolve taken
    v = '0; v.br = 1'b1; v.exmr = 1'b1; v.exrd = 5'd7; v.rs1 = 5'd7;
    apply(v, BUBBLE);
    v = '0; v.br = 1'b1; v.memmr = 1'b1; v.memrd = 5'd7; v.rs1 = 5'd7;
    apply(v, BUBBLE);
    v = '0; v.br = 1'b1; v.rs1 = 5'd7; v.taken = 1'b1;
    apply(v, FLUSH);
    v = '0; apply(v, RUN_OK);

    // branch on ALU result in EX
    v = '0; v.br = 1'b1; v.exrw = 1'b1; v.exrd = 5'd3; v.rs2 = 5'd3; v.use_rs2 = 1'b1;
    apply(v, BUBBLE);
    // jalr ignores rs2 even with use_rs2 set
    v = '0; v.jalr = 1'b1; v.exrw = 1'b1; v.exrd = 5'd3; v.rs2 = 5'd3; v.use_rs2 = 1'b1; v.rs1 = 5'd4;
    apply(v, RUN_OK);
    // jalr on a load in MEM
    v = '0; v.jalr = 1'b1; v.memmr = 1'b1; v.memrd = 5'd4; v.rs1 = 5'd4;
    apply(v, BUBBLE);
    // taken ignored while a hazard applies
    v = '0; v.br = 1'b1; v.exrw = 1'b1; v.exrd = 5'd3; v.rs1 = 5'd3; v.taken = 1'b1;
    apply(v, BUBBLE);

    // taken branch during a 3-cycle dcache freeze
    v = '0; v.taken = 1'b1; v.dc = 1'b1;
    repeat (3) apply(v, FREEZE);
    v = '0; v.taken = 1'b1;
    apply(v, FLUSH);

    // icache freeze during WAIT defers the pending bubble
    v = '0; v.jalr = 1'b1; v.exmr = 1'b1; v.exrd = 5'd6; v.rs1 = 5'd6;
    apply(v, BUBBLE);
    v = '0; v.ic = 1'b1;
    repeat (2) apply(v, FREEZE);
    v = '0; apply(v, BUBBLE);
    v = '0; apply(v, RUN_OK);

    // reset while in WAIT: no bubble afterwards, counters cleared
    v = '0; v.br = 1'b1; v.exmr = 1'b1; v.exrd = 5'd6; v.rs1 = 5'd6;
    apply(v, BUBBLE);
    v = '0; v.rst = 1'b1; apply(v, RUN_OK);
    v = '0; apply(v, RUN_OK);

    // 20 load-use stalls: 4-bit counter saturates at 15
    v = '0; v.exmr = 1'b1; v.exrd = 5'd9; v.rs1 = 5'd9;
    repeat (20) apply(v, BUBBLE);
    v = '0; apply(v, RUN_OK);
    v = '0; apply(v, RUN_OK);

    for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d pending required=0", sb_q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
